// File: rtl/ad_avg.sv
// Block-averaging decimator: accumulates 2^LOG2_N accepted samples and
// presents the truncated mean plus block min/max as one registered result.
module ad_avg #(
  parameter int LOG2_N = 4
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] ad_data,
  input  logic        ad_vld,
  output logic [15:0] avg_data,
  output logic [15:0] avg_min,
  output logic [15:0] avg_max,
  output logic [7:0]  avg_seq,
  output logic        avg_vld
);

  // state | meaning
  // IDLE  | en low; working registers held clear, ad_vld ignored
  // ACC   | en high; accepted samples accumulate into the current block
  typedef enum logic {IDLE, ACC} state_t;

  localparam int AW = 16 + LOG2_N;
  localparam int CW = (LOG2_N > 0) ? LOG2_N : 1;
  localparam logic [CW-1:0] LAST = CW'((1 << LOG2_N) - 1);

  state_t         state, state_nxt;
  logic [AW-1:0]  acc, sum;
  logic [CW-1:0]  cnt;
  logic [15:0]    run_min, run_max, min_nxt, max_nxt;
  logic           accept, clr, last;

  always_comb begin
    state_nxt = IDLE;
    accept    = 1'b0;
    clr       = 1'b1;
    case (state)
      IDLE: begin
        if (en) state_nxt = ACC;
      end
      ACC: begin
        if (en) begin
          state_nxt = ACC;
          clr       = 1'b0;
          accept    = ad_vld;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A sample arriving with cnt==0 opens a block and seeds both extremes.
  always_comb begin
    sum     = acc + AW'(ad_data);
    last    = (cnt == LAST);
    min_nxt = ((cnt == '0) || (ad_data < run_min)) ? ad_data : run_min;
    max_nxt = ((cnt == '0) || (ad_data > run_max)) ? ad_data : run_max;
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      run_min  <= '0;
      run_max  <= '0;
      avg_data <= '0;
      avg_min  <= '0;
      avg_max  <= '0;
      avg_seq  <= '0;
      avg_vld  <= 1'b0;
    end else begin
      state   <= state_nxt;
      avg_vld <= 1'b0;
      if (clr) begin
        acc     <= '0;
        cnt     <= '0;
        run_min <= '0;
        run_max <= '0;
      end else if (accept) begin
        if (last) begin
          // Clearing in the completing edge lets the next block start gap-free.
          avg_data <= sum[AW-1 -: 16];
          avg_min  <= min_nxt;
          avg_max  <= max_nxt;
          avg_seq  <= avg_seq + 8'd1;
          avg_vld  <= 1'b1;
          acc      <= '0;
          cnt      <= '0;
          run_min  <= '0;
          run_max  <= '0;
        end else begin
          acc     <= sum;
          cnt     <= cnt + CW'(1);
          run_min <= min_nxt;
          run_max <= max_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_ad_avg.sv
// Self-checking bench for ad_avg: two instances (LOG2_N=4 and 0) checked every
// cycle against a queue-based block model, plus literal checks from the test plan.
module tb_ad_avg;

  logic        clk_sys = 1'b0;
  logic        rst, en, ad_vld;
  logic [15:0] ad_data;

  logic [15:0] d4_data, d4_min, d4_max, d0_data, d0_min, d0_max;
  logic [7:0]  d4_seq, d0_seq;
  logic        d4_vld, d0_vld;

  int vectors = 0;
  int errors  = 0;

  always #5 clk_sys = ~clk_sys;

  ad_avg #(.LOG2_N(4)) u_dut4 (
    .clk_sys(clk_sys), .rst(rst), .en(en), .ad_data(ad_data), .ad_vld(ad_vld),
    .avg_data(d4_data), .avg_min(d4_min), .avg_max(d4_max),
    .avg_seq(d4_seq), .avg_vld(d4_vld)
  );

  ad_avg #(.LOG2_N(0)) u_dut0 (
    .clk_sys(clk_sys), .rst(rst), .en(en), .ad_data(ad_data), .ad_vld(ad_vld),
    .avg_data(d0_data), .avg_min(d0_min), .avg_max(d0_max),
    .avg_seq(d0_seq), .avg_vld(d0_vld)
  );

  // Behavioural model: index 0 mirrors u_dut4, index 1 mirrors u_dut0.
  int          blk_len [2] = '{16, 1};
  logic [15:0] blk_q0 [$];
  logic [15:0] blk_q1 [$];
  bit          in_acc = 1'b0;
  logic [15:0] m_data [2] = '{16'h0, 16'h0};
  logic [15:0] m_min  [2] = '{16'h0, 16'h0};
  logic [15:0] m_max  [2] = '{16'h0, 16'h0};
  logic [7:0]  m_seq  [2] = '{8'h0, 8'h0};
  bit          m_vld  [2] = '{1'b0, 1'b0};

  task automatic close_block(input int k, input logic [15:0] blk[$]);
    longint s = 0;
    logic [15:0] mn = 16'hFFFF, mx = 16'h0000;
    foreach (blk[i]) begin
      s += blk[i];
      if (blk[i] < mn) mn = blk[i];
      if (blk[i] > mx) mx = blk[i];
    end
    m_data[k] = 16'(s / blk_len[k]);
    m_min[k]  = mn;
    m_max[k]  = mx;
    m_seq[k]  = m_seq[k] + 8'd1;
    m_vld[k]  = 1'b1;
  endtask

  always @(posedge clk_sys) begin
    m_vld[0] = 1'b0;
    m_vld[1] = 1'b0;
    if (rst) begin
      blk_q0.delete(); blk_q1.delete();
      for (int k = 0; k < 2; k++) begin
        m_data[k] = 0; m_min[k] = 0; m_max[k] = 0; m_seq[k] = 0;
      end
      in_acc = 1'b0;
    end else begin
      if (!(en && in_acc)) begin
        blk_q0.delete(); blk_q1.delete();
      end else if (ad_vld) begin
        blk_q0.push_back(ad_data);
        blk_q1.push_back(ad_data);
        if (blk_q0.size() == blk_len[0]) begin close_block(0, blk_q0); blk_q0.delete(); end
        if (blk_q1.size() == blk_len[1]) begin close_block(1, blk_q1); blk_q1.delete(); end
      end
      in_acc = en;
    end
  end

  task automatic cmp_inst(input int k, input logic [15:0] dd, input logic [15:0] dmn,
                          input logic [15:0] dmx, input logic [7:0] dsq, input logic dv);
    vectors++;
    if (dv !== m_vld[k] || (m_vld[k] && (dd !== m_data[k] || dmn !== m_min[k] || dmx !== m_max[k]))
        || dd !== m_data[k] || dsq !== m_seq[k]) begin
      errors++;
      $display("FAIL model_inst%0d t=%0t got vld=%b data=%h min=%h max=%h seq=%h want vld=%b data=%h min=%h max=%h seq=%h",
               k, $time, dv, dd, dmn, dmx, dsq, m_vld[k], m_data[k], m_min[k], m_max[k], m_seq[k]);
    end
  endtask

  always @(negedge clk_sys) begin
    cmp_inst(0, d4_data, d4_min, d4_max, d4_seq, d4_vld);
    cmp_inst(1, d0_data, d0_min, d0_max, d0_seq, d0_vld);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic v, input logic [15:0] d);
    rst = r; en = e; ad_vld = v; ad_data = d;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic restart();
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
  endtask

  int pulses;

  initial begin
    rst = 1'b1; en = 1'b0; ad_vld = 1'b0; ad_data = 16'h0;
    step(1, 0, 0, 0);
    check("reset_data", d4_data, 0);
    check("reset_minmax", {d4_min, d4_max}, 0);
    check("reset_seq_vld", {d4_seq, d4_vld}, 0);

    // Ramp average; en rises together with a sample that must not count
    step(0, 1, 1, 16'hDEAD);
    for (int i = 0; i < 16; i++) step(0, 1, 1, 16'h1000 + 16'(i) * 16'h0100);
    check("ramp_vld", d4_vld, 1);
    check("ramp_data", d4_data, 16'h1780);
    check("ramp_min", d4_min, 16'h1000);
    check("ramp_max", d4_max, 16'h1F00);
    check("ramp_seq", d4_seq, 8'h01);

    // Truncation and full scale
    restart();
    for (int i = 0; i < 15; i++) step(0, 1, 1, 16'h0000);
    step(0, 1, 1, 16'h0010);
    check("trunc_data", d4_data, 16'h0001);
    for (int i = 0; i < 16; i++) step(0, 1, 1, 16'hFFF0);
    check("fullscale_data", d4_data, 16'hFFF0);

    // Back-to-back throughput
    restart();
    pulses = 0;
    for (int i = 1; i <= 32; i++) begin
      step(0, 1, 1, 16'(i * 37));
      if (d4_vld) pulses++;
      if (i == 15) check("b2b_no_early", d4_vld, 0);
      if (i == 16) check("b2b_seq1", {d4_vld, d4_seq}, {1'b1, 8'h01});
      if (i == 32) check("b2b_seq2", {d4_vld, d4_seq}, {1'b1, 8'h02});
    end
    check("b2b_pulses", pulses, 2);

    // Enable abort, including a would-be final sample with en low
    restart();
    pulses = 0;
    for (int i = 0; i < 7; i++) step(0, 1, 1, 16'h8000);
    step(0, 0, 1, 16'h8000);
    if (d4_vld) pulses++;
    step(0, 1, 0, 0);
    for (int i = 0; i < 15; i++) begin step(0, 1, 1, 16'h8000); if (d4_vld) pulses++; end
    step(0, 0, 1, 16'h8000);
    if (d4_vld) pulses++;
    check("abort_no_vld", pulses, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 1, 16'h2000);
    check("abort_data", d4_data, 16'h2000);
    check("abort_max", d4_max, 16'h2000);

    // Reset mid-block
    for (int i = 0; i < 10; i++) step(0, 1, 1, 16'h7777);
    step(1, 1, 1, 16'h7777);
    check("rst_outputs", {d4_data, d4_min, d4_max, d4_seq, 7'd0, d4_vld}, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 1, 16'h4000);
    check("rst_data", d4_data, 16'h4000);
    check("rst_seq", d4_seq, 8'h01);

    // Sequence wrap on the LOG2_N=0 instance
    restart();
    pulses = 0;
    for (int i = 1; i <= 257; i++) begin
      logic [15:0] smp;
      smp = 16'($urandom);
      step(0, 1, 1, smp);
      if (d0_vld) pulses++;
      check("wrap_data", {d0_vld, d0_data, d0_min, d0_max}, {1'b1, smp, smp, smp});
      if (pulses == 255 && i == 255) check("wrap_seq255", d0_seq, 8'hFF);
      if (pulses == 256 && i == 256) check("wrap_seq256", d0_seq, 8'h00);
      if (pulses == 257 && i == 257) check("wrap_seq257", d0_seq, 8'h01);
    end
    check("wrap_pulses", pulses, 257);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] d;
      case ($urandom_range(0, 3))
        0: d = 16'h0000;
        1: d = 16'hFFFF;
        default: d = 16'($urandom);
      endcase
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 19) != 0),
           ($urandom_range(0, 3) != 0), d);
    end
    step(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
